// File: rtl/rom_req_fifo_writer_if.sv
// Burst-request handshake and FWFT read port of the ROM request FIFO writer.
// master drives requests and pops entries; slave is the writer block itself.
interface rom_req_fifo_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_offset;
    logic [4:0]  req_len;
    logic        is_empty;
    logic [11:0] data_to_reader;
    logic        rd_en;

    modport master (
        output req_valid, req_offset, req_len, rd_en,
        input  req_ready, is_empty, data_to_reader
    );

    modport slave (
        input  req_valid, req_offset, req_len, rd_en,
        output req_ready, is_empty, data_to_reader
    );
endinterface

// File: rtl/rom_req_fifo_writer.sv
// Expands {offset, len} bursts into {tag, offset} entries in a FWFT FIFO for the ROM reader.
// Optional sticky underflow flag enabled by defining REQ_FIFO_UNDERFLOW_EN.
module rom_req_fifo_writer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rom_req_fifo_writer_if.slave    bus,
    output logic                    o_busy,
`ifdef REQ_FIFO_UNDERFLOW_EN
    output logic                    o_rd_underflow,
`endif
    output logic [PTR_W:0]          o_fill_count
);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [11:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [3:0]       r_tag;
    logic [7:0]       r_cur_off;
    logic [4:0]       r_remaining;

    logic w_empty;
    logic w_pop;
    logic w_push_ok;
    logic w_push;
    logic w_accept;

    assign w_empty   = (r_count == '0);
    assign w_pop     = bus.rd_en && !w_empty;
    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign w_push_ok = (r_count < (PTR_W+1)'(DEPTH)) || w_pop;
    assign w_push    = (r_state == StIssue) && w_push_ok;
    assign w_accept  = (r_state == StIdle) && bus.req_valid && (bus.req_len != '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StIssue;
            StIssue: if (w_push && (r_remaining == 5'd1)) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_tag       <= '0;
            r_cur_off   <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cur_off   <= bus.req_offset;
                r_remaining <= bus.req_len;
            end else if (w_push) begin
                r_cur_off   <= r_cur_off + 8'd1;
                r_tag       <= r_tag + 4'd1;
                r_remaining <= r_remaining - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which words are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_tag, r_cur_off};
    end

`ifdef REQ_FIFO_UNDERFLOW_EN
    logic r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (bus.rd_en && w_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign o_rd_underflow = r_underflow;
`endif

    assign bus.req_ready      = (r_state == StIdle);
    assign o_busy             = (r_state == StIssue);
    assign bus.is_empty       = w_empty;
    assign bus.data_to_reader = r_mem[r_rd_ptr];
    assign o_fill_count       = r_count;

endmodule

// File: tb/tb_rom_req_fifo_writer.sv
// Self-checking bench for rom_req_fifo_writer: directed steps plus random traffic vs a queue model.
module tb_rom_req_fifo_writer;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [PTR_W:0] fill_count;
`ifdef REQ_FIFO_UNDERFLOW_EN
    logic rd_underflow;
`endif

    rom_req_fifo_writer_if bus ();

    rom_req_fifo_writer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .o_busy        (busy),
`ifdef REQ_FIFO_UNDERFLOW_EN
        .o_rd_underflow(rd_underflow),
`endif
        .o_fill_count  (fill_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: list of pending entries, outstanding burst, free-running tag.
    logic [11:0] m_q[$];
    int m_rem = 0;
    int m_off = 0;
    int m_tag = 0;
    bit m_uf  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rem = 0;
        m_off = 0;
        m_tag = 0;
        m_uf  = 0;
    endtask

    task automatic model_step();
        bit pop;
        bit push;
        int rem_old;
        rem_old = m_rem;
        pop  = bus.rd_en && (m_q.size() > 0);
        push = (m_rem > 0) && ((m_q.size() < DEPTH) || pop);
        if (bus.rd_en && m_q.size() == 0) m_uf = 1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back({4'(m_tag), 8'(m_off)});
            m_tag = (m_tag + 1) % 16;
            m_off = (m_off + 1) % 256;
            m_rem--;
        end
        if (rem_old == 0 && bus.req_valid && bus.req_len != 0) begin
            m_rem = int'(bus.req_len);
            m_off = int'(bus.req_offset);
        end
    endtask

    task automatic check_outputs();
        chk("req_ready", 32'(bus.req_ready), 32'(m_rem == 0));
        chk("busy", 32'(busy), 32'(m_rem != 0));
        chk("is_empty", 32'(bus.is_empty), 32'(m_q.size() == 0));
        chk("fill_count", 32'(fill_count), 32'(m_q.size()));
        if (m_q.size() > 0) chk("data_to_reader", 32'(bus.data_to_reader), 32'(m_q[0]));
`ifdef REQ_FIFO_UNDERFLOW_EN
        chk("rd_underflow", 32'(rd_underflow), 32'(m_uf));
`endif
    endtask

    task automatic cycle();
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic request(input logic [7:0] off, input logic [4:0] len);
        bus.req_valid  = 1'b1;
        bus.req_offset = off;
        bus.req_len    = len;
        cycle();
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 64) begin
            cycle();
            n++;
        end
        chk("wait_ready_timeout", 32'(n < 64), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        bus.rd_en = 1'b1;
        while ((bus.is_empty !== 1'b1 || busy !== 1'b0) && n < 200) begin
            cycle();
            n++;
        end
        bus.rd_en = 1'b0;
        chk("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    logic [11:0] exp_wrap [4];

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_offset = '0;
        bus.req_len    = '0;
        bus.rd_en      = 1'b0;
        model_reset();
        #12;
        check_outputs();
        chk("reset_fill", 32'(fill_count), 32'd0);
        chk("reset_empty", 32'(bus.is_empty), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short burst with idle reader.
        request(8'h10, 5'd3);
        repeat (3) cycle();
        chk("b1_busy_low", 32'(busy), 32'd0);
        chk("b1_fill", 32'(fill_count), 32'd3);
        chk("b1_head", 32'(bus.data_to_reader), 32'h010);
        drain();

        // Advance tag to 14, then a burst that wraps both offset and tag.
        request(8'h30, 5'd11);
        wait_ready();
        drain();
        request(8'hFE, 5'd4);
        wait_ready();
        chk("wrap_fill", 32'(fill_count), 32'd4);
        exp_wrap[0] = 12'hEFE;
        exp_wrap[1] = 12'hFFF;
        exp_wrap[2] = 12'h000;
        exp_wrap[3] = 12'h101;
        for (int i = 0; i < 4; i++) begin
            chk("wrap_entry", 32'(bus.data_to_reader), 32'(exp_wrap[i]));
            bus.rd_en = 1'b1;
            cycle();
            bus.rd_en = 1'b0;
        end
        chk("wrap_empty", 32'(bus.is_empty), 32'd1);

        // Fill to full, then a second burst that stalls.
        request(8'h40, 5'd16);
        wait_ready();
        request(8'h60, 5'd2);
        repeat (4) cycle();
        chk("stall_fill", 32'(fill_count), 32'd16);
        chk("stall_busy", 32'(busy), 32'd1);
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        chk("full_pop_fill", 32'(fill_count), 32'd16);
        repeat (3) cycle();
        chk("stall_resume_busy", 32'(busy), 32'd1);
        chk("stall_resume_fill", 32'(fill_count), 32'd16);
        drain();

        // Zero-length request is swallowed.
        request(8'h77, 5'd0);
        chk("len0_ready", 32'(bus.req_ready), 32'd1);
        chk("len0_empty", 32'(bus.is_empty), 32'd1);
        cycle();
        request(8'h50, 5'd1);
        cycle();
        chk("len0_tag_kept", 32'(bus.data_to_reader), 32'h450);
        drain();

        // Reset in the middle of a burst.
        request(8'h80, 5'd10);
        repeat (4) cycle();
        chk("pre_reset_fill", 32'(fill_count), 32'd4);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("mid_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        request(8'h20, 5'd1);
        cycle();
        chk("post_reset_entry", 32'(bus.data_to_reader), 32'h020);
        drain();

`ifdef REQ_FIFO_UNDERFLOW_EN
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        cycle();
        chk("underflow_set", 32'(rd_underflow), 32'd1);
        chk("underflow_fill", 32'(fill_count), 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.req_valid  = 1'($urandom % 2);
            bus.req_offset = 8'($urandom);
            bus.req_len    = 5'($urandom_range(0, 16));
            bus.rd_en      = 1'(($urandom % 3) == 0);
            cycle();
        end
        bus.req_valid = 1'b0;
        drain();
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
